// File: rtl/fu_wb_collector_pkg.sv
// Shared types and defaults for FU writeback collection, used by FU wrappers and the CDB arbiter.
package fu_wb_collector_pkg;

    localparam int unsigned DEPTH_DEF  = 4;
    localparam int unsigned TAG_W_DEF  = 5;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned PTR_W_DEF  = $clog2(DEPTH_DEF);

    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic [DATA_W_DEF-1:0] data;
    } wb_entry_t;

    // Pointer width for a power-of-two FIFO, never below one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fu_wb_collector_sync_fifo.sv
// Synchronous FIFO with occupancy counter; clear empties it in one cycle, head is read from storage.
module sync_fifo
    import fu_wb_collector_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        full    = (count == CNT_W'(DEPTH));
        empty   = (count == '0);
        push_ok = push & ~full;
        pop_ok  = pop & ~empty;
        head    = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/fu_wb_collector.sv
// Issue/writeback collector for one in-order multi-cycle FU: credits, tag pairing, result buffering.
// Optional FU_WB_BYPASS_EN forwards a finishing result straight to writeback when the buffer is empty.
module fu_wb_collector
    import fu_wb_collector_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [TAG_W-1:0]  issue_tag,
    output logic              issue_ready,
    output logic              fu_en,
    input  logic              fu_finish,
    input  logic [DATA_W-1:0] fu_res,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_ready,
    input  logic              flush,
    output logic              proto_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W = TAG_W + DATA_W;

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] drop_cnt;

    logic [TAG_W-1:0] tag_head;
    logic             tag_full;
    logic             tag_empty;
    logic [CNT_W-1:0] tag_count;
    logic             tag_pop;

    logic [ENT_W-1:0] res_head;
    logic             res_full;
    logic             res_empty;
    logic [CNT_W-1:0] res_count;
    logic             res_push;
    logic             res_pop;

    logic             drop_any;
    logic             fin_match;
    logic             fin_orphan;
    logic             bypass;
    logic             pop;
    logic [CNT_W-1:0] flush_drops;

    // Completion classification, credit and writeback selection.
    always_comb begin
        issue_ready = (count < CNT_W'(DEPTH)) & ~tag_full & ~flush;
        fu_en       = issue_valid & issue_ready;

        drop_any   = fu_finish & (drop_cnt != '0);
        fin_match  = fu_finish & ~drop_any & ~tag_empty;
        fin_orphan = fu_finish & (drop_cnt == '0) & tag_empty;

`ifdef FU_WB_BYPASS_EN
        bypass = fin_match & res_empty & ~flush;
`else
        bypass = 1'b0;
`endif

        wb_valid = ~res_empty | bypass;
        if (bypass) begin
            wb_tag  = tag_head;
            wb_data = fu_res;
        end else begin
            wb_tag  = res_head[ENT_W-1:DATA_W];
            wb_data = res_head[DATA_W-1:0];
        end

        pop      = wb_valid & wb_ready & ~flush;
        res_pop  = pop & ~bypass;
        res_push = fin_match & ~(bypass & wb_ready) & ~res_full;
        tag_pop  = fin_match;

        // A finish landing in the flush cycle retires one of the results still owed by the FU.
        flush_drops = drop_cnt + tag_count
                    - CNT_W'(fu_finish & ((drop_cnt != '0) | ~tag_empty));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            drop_cnt  <= '0;
            proto_err <= 1'b0;
        end else begin
            if (fin_orphan) begin
                proto_err <= 1'b1;
            end
            if (flush) begin
                count    <= flush_drops;
                drop_cnt <= flush_drops;
            end else begin
                count    <= count + CNT_W'(fu_en) - CNT_W'(drop_any) - CNT_W'(pop);
                drop_cnt <= drop_cnt - CNT_W'(drop_any);
            end
        end
    end

    // Every credit is owned by exactly one of: an in-flight tag, a buffered result, a pending drop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count == tag_count + res_count + drop_cnt)
                else $error("credit accounting out of step");
        end
    end

    sync_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (fu_en),
        .push_data (issue_tag),
        .pop       (tag_pop),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (res_push),
        .push_data ({tag_head, fu_res}),
        .pop       (res_pop),
        .head      (res_head),
        .full      (res_full),
        .empty     (res_empty),
        .count     (res_count)
    );

endmodule

// File: tb/tb_fu_wb_collector.sv
// Self-checking bench for fu_wb_collector (default build): directed scenarios plus randomized traffic vs a queue model.
module tb_fu_wb_collector;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_valid = 1'b0;
    logic [TAG_W-1:0]  issue_tag = '0;
    logic              issue_ready;
    logic              fu_en;
    logic              fu_finish = 1'b0;
    logic [DATA_W-1:0] fu_res = '0;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready = 1'b0;
    logic              flush = 1'b0;
    logic              proto_err;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fu_wb_collector #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_tag   (issue_tag),
        .issue_ready (issue_ready),
        .fu_en       (fu_en),
        .fu_finish   (fu_finish),
        .fu_res      (fu_res),
        .wb_valid    (wb_valid),
        .wb_tag      (wb_tag),
        .wb_data     (wb_data),
        .wb_ready    (wb_ready),
        .flush       (flush),
        .proto_err   (proto_err)
    );

    // Reference model: ops still owed by the FU, buffered results, owed-but-flushed results.
    typedef struct {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic [TAG_W-1:0] m_inflight[$];
    ent_t             m_buf[$];
    int               m_drop = 0;
    bit               m_err = 1'b0;

    function automatic int m_credit();
        return m_inflight.size() + m_buf.size() + m_drop;
    endfunction

    task automatic model_edge();
        ent_t e;
        bit   acc;
        int   owed;
        if (rst) begin
            m_inflight.delete();
            m_buf.delete();
            m_drop = 0;
            m_err  = 1'b0;
        end else if (flush) begin
            owed = m_drop + m_inflight.size();
            if (fu_finish) begin
                if (owed > 0) owed--;
                else m_err = 1'b1;
            end
            m_inflight.delete();
            m_buf.delete();
            m_drop = owed;
        end else begin
            acc = issue_valid && (m_credit() < DEPTH);
            if (wb_ready && m_buf.size() > 0) e = m_buf.pop_front();
            if (fu_finish) begin
                if (m_drop > 0) m_drop--;
                else if (m_inflight.size() > 0) begin
                    e.tag  = m_inflight.pop_front();
                    e.data = fu_res;
                    m_buf.push_back(e);
                end else m_err = 1'b1;
            end
            if (acc) m_inflight.push_back(issue_tag);
        end
    endtask

    task automatic set_in(input bit iv, input logic [TAG_W-1:0] tg, input bit fin,
                          input logic [DATA_W-1:0] res, input bit wr, input bit fl);
        issue_valid = iv;
        issue_tag   = tg;
        fu_finish   = fin;
        fu_res      = res;
        wb_ready    = wr;
        flush       = fl;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (issue_ready !== 1'b1) begin failed++; $display("FAIL reset_issue_ready got=%b exp=1", issue_ready); end
        tests++; if (fu_en !== 1'b0) begin failed++; $display("FAIL reset_fu_en got=%b exp=0", fu_en); end
        tests++; if (wb_valid !== 1'b0) begin failed++; $display("FAIL reset_wb_valid got=%b exp=0", wb_valid); end
        tests++; if (wb_tag !== '0 || wb_data !== '0) begin failed++; $display("FAIL reset_wb_payload got=%h/%h exp=0/0", wb_tag, wb_data); end
        tests++; if (proto_err !== 1'b0) begin failed++; $display("FAIL reset_proto_err got=%b exp=0", proto_err); end
    endtask

    task automatic test_single_op();
        set_in(1'b1, 5'd5, 1'b0, '0, 1'b1, 1'b0);
        #1;
        tests++; if (fu_en !== 1'b1) begin failed++; $display("FAIL single_fu_en got=%b exp=1", fu_en); end
        step();
        for (int i = 0; i < 6; i++) begin
            set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
            step();
        end
        tests++; if (wb_valid !== 1'b0) begin failed++; $display("FAIL single_early_valid got=%b exp=0", wb_valid); end
        set_in(1'b0, '0, 1'b1, 32'h0000_0030, 1'b1, 1'b0);
        step();
        tests++; if (wb_valid !== 1'b1) begin failed++; $display("FAIL single_valid got=%b exp=1", wb_valid); end
        tests++; if (wb_tag !== 5'd5 || wb_data !== 32'h30) begin failed++; $display("FAIL single_payload got=%0d/%h exp=5/00000030", wb_tag, wb_data); end
        set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step();
        tests++; if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin failed++; $display("FAIL single_drained got valid=%b ready=%b exp 0/1", wb_valid, issue_ready); end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b1, TAG_W'(i), 1'b0, '0, 1'b0, 1'b0);
            step();
        end
        tests++; if (issue_ready !== 1'b0) begin failed++; $display("FAIL full_issue_ready got=%b exp=0", issue_ready); end
        set_in(1'b1, 5'd7, 1'b0, '0, 1'b0, 1'b0);
        #1;
        tests++; if (fu_en !== 1'b0) begin failed++; $display("FAIL full_fu_en got=%b exp=0", fu_en); end
        step();
        for (int i = 1; i <= 4; i++) begin
            set_in(1'b0, '0, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
            step();
        end
        tests++; if (wb_valid !== 1'b1 || issue_ready !== 1'b0) begin failed++; $display("FAIL full_buffered got valid=%b ready=%b exp 1/0", wb_valid, issue_ready); end
        for (int i = 1; i <= 4; i++) begin
            tests++;
            if (wb_valid !== 1'b1 || wb_tag !== TAG_W'(i) || wb_data !== 32'h100 + 32'(i)) begin
                failed++; $display("FAIL full_drain_%0d got v=%b %0d/%h exp 1 %0d/%h", i, wb_valid, wb_tag, wb_data, i, 32'h100 + 32'(i));
            end
            set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
            step();
            if (i == 1) begin
                tests++; if (issue_ready !== 1'b1) begin failed++; $display("FAIL full_ready_after_pop got=%b exp=1", issue_ready); end
            end
        end
        tests++; if (wb_valid !== 1'b0) begin failed++; $display("FAIL full_empty got=%b exp=0", wb_valid); end
    endtask

    task automatic test_simultaneous();
        logic [TAG_W-1:0]  et [3];
        logic [DATA_W-1:0] ed [3];
        et = '{5'd11, 5'd12, 5'd13};
        ed = '{32'h66, 32'h77, 32'h88};
        for (int i = 10; i <= 12; i++) begin
            set_in(1'b1, TAG_W'(i), 1'b0, '0, 1'b0, 1'b0);
            step();
        end
        set_in(1'b0, '0, 1'b1, 32'h55, 1'b0, 1'b0);
        step();
        tests++; if (wb_tag !== 5'd10 || issue_ready !== 1'b1) begin failed++; $display("FAIL simul_setup got tag=%0d ready=%b exp 10/1", wb_tag, issue_ready); end
        set_in(1'b1, 5'd13, 1'b1, 32'h66, 1'b1, 1'b0);
        #1;
        tests++; if (fu_en !== 1'b1) begin failed++; $display("FAIL simul_fu_en got=%b exp=1", fu_en); end
        step();
        tests++; if (wb_valid !== 1'b1 || wb_tag !== 5'd11 || wb_data !== 32'h66 || issue_ready !== 1'b1) begin
            failed++; $display("FAIL simul_after got v=%b %0d/%h ready=%b exp 1 11/66 1", wb_valid, wb_tag, wb_data, issue_ready);
        end
        set_in(1'b0, '0, 1'b1, 32'h77, 1'b0, 1'b0);
        step();
        set_in(1'b0, '0, 1'b1, 32'h88, 1'b0, 1'b0);
        step();
        tests++; if (issue_ready !== 1'b1) begin failed++; $display("FAIL simul_count3 got=%b exp=1", issue_ready); end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (wb_valid !== 1'b1 || wb_tag !== et[i] || wb_data !== ed[i]) begin
                failed++; $display("FAIL simul_order_%0d got v=%b %0d/%h exp 1 %0d/%h", i, wb_valid, wb_tag, wb_data, et[i], ed[i]);
            end
            set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
            step();
        end
        tests++; if (wb_valid !== 1'b0) begin failed++; $display("FAIL simul_empty got=%b exp=0", wb_valid); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, TAG_W'(i), 1'b0, '0, 1'b0, 1'b0);
            step();
        end
        set_in(1'b0, '0, 1'b1, 32'hAA, 1'b0, 1'b0);
        step();
        set_in(1'b1, 5'd20, 1'b0, '0, 1'b1, 1'b1);
        #1;
        tests++; if (fu_en !== 1'b0 || issue_ready !== 1'b0) begin failed++; $display("FAIL flush_same_cycle got en=%b ready=%b exp 0/0", fu_en, issue_ready); end
        step();
        tests++; if (wb_valid !== 1'b0 || issue_ready !== 1'b1) begin failed++; $display("FAIL flush_next got valid=%b ready=%b exp 0/1", wb_valid, issue_ready); end
        set_in(1'b1, 5'd9, 1'b0, '0, 1'b0, 1'b0);
        step();
        set_in(1'b0, '0, 1'b1, 32'hA, 1'b0, 1'b0);
        step();
        set_in(1'b0, '0, 1'b1, 32'hB, 1'b0, 1'b0);
        step();
        tests++; if (wb_valid !== 1'b0) begin failed++; $display("FAIL flush_dropped got valid=%b exp=0", wb_valid); end
        set_in(1'b0, '0, 1'b1, 32'hC, 1'b0, 1'b0);
        step();
        tests++; if (wb_valid !== 1'b1 || wb_tag !== 5'd9 || wb_data !== 32'hC) begin
            failed++; $display("FAIL flush_survivor got v=%b %0d/%h exp 1 9/0000000c", wb_valid, wb_tag, wb_data);
        end
        set_in(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        step();
        tests++; if (wb_valid !== 1'b0 || proto_err !== 1'b0) begin failed++; $display("FAIL flush_end got valid=%b err=%b exp 0/0", wb_valid, proto_err); end
    endtask

    task automatic test_proto_err();
        set_in(1'b0, '0, 1'b1, 32'h77, 1'b1, 1'b0);
        step();
        tests++; if (proto_err !== 1'b1 || wb_valid !== 1'b0) begin failed++; $display("FAIL perr_set got err=%b valid=%b exp 1/0", proto_err, wb_valid); end
        step();
        step();
        tests++; if (proto_err !== 1'b1) begin failed++; $display("FAIL perr_sticky got=%b exp=1", proto_err); end
        do_reset();
        tests++; if (proto_err !== 1'b0) begin failed++; $display("FAIL perr_cleared got=%b exp=0", proto_err); end
    endtask

    task automatic test_reset_mid();
        for (int i = 4; i <= 6; i++) begin
            set_in(1'b1, TAG_W'(i), 1'b0, '0, 1'b0, 1'b0);
            step();
        end
        set_in(1'b0, '0, 1'b1, 32'h99, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        set_in(1'b1, 5'd1, 1'b1, 32'h42, 1'b1, 1'b1);
        step();
        rst = 1'b0;
        tests++; if (issue_ready !== 1'b1 || wb_valid !== 1'b0 || proto_err !== 1'b0 || wb_tag !== '0 || wb_data !== '0) begin
            failed++; $display("FAIL rstmid_outputs got ready=%b v=%b err=%b %0d/%h exp 1 0 0 0/0", issue_ready, wb_valid, proto_err, wb_tag, wb_data);
        end
        set_in(1'b0, '0, 1'b1, 32'h5, 1'b0, 1'b0);
        step();
        tests++; if (proto_err !== 1'b1 || wb_valid !== 1'b0) begin failed++; $display("FAIL rstmid_orphan got err=%b valid=%b exp 1/0", proto_err, wb_valid); end
        do_reset();
    endtask

    task automatic test_random();
        bit               iv, fin, wr, fl;
        logic [TAG_W-1:0] tg;
        bit               exp_ready;
        for (int c = 0; c < 1500; c++) begin
            iv  = ($urandom_range(0, 1) == 1);
            tg  = TAG_W'($urandom);
            fin = ((m_drop + m_inflight.size()) > 0) && ($urandom_range(0, 2) != 0);
            wr  = ((c / 100) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 39) == 0);
            set_in(iv, tg, fin, $urandom, wr, fl);
            #1;
            exp_ready = (m_credit() < DEPTH) && !fl;
            tests++;
            if (issue_ready !== exp_ready || fu_en !== (iv && exp_ready)) begin
                failed++; $display("FAIL rand_issue c=%0d got ready=%b en=%b exp %b/%b", c, issue_ready, fu_en, exp_ready, iv && exp_ready);
            end
            tests++;
            if (wb_valid !== (m_buf.size() > 0) || proto_err !== m_err) begin
                failed++; $display("FAIL rand_status c=%0d got valid=%b err=%b exp %b/%b", c, wb_valid, proto_err, m_buf.size() > 0, m_err);
            end
            if (m_buf.size() > 0) begin
                tests++;
                if (wb_tag !== m_buf[0].tag || wb_data !== m_buf[0].data) begin
                    failed++; $display("FAIL rand_head c=%0d got %0d/%h exp %0d/%h", c, wb_tag, wb_data, m_buf[0].tag, m_buf[0].data);
                end
            end
            step();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_full();
        test_simultaneous();
        test_flush();
        test_proto_err();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/fu_wb_collector.md
Name: fu_wb_collector

Overview:
- Consumer/issue end of the functional-unit EN/finish protocol.
- Issues operations to one in-order multi-cycle FU (multiplier, divider) by pulsing the FU's EN.
- Records each op's destination tag and pairs returning results (finish + res) with tags in issue order.
- Buffers tagged results and presents them to the writeback/CDB stage with a valid/ready handshake, so the FU never stalls on a busy bus.

Parameters:
DEPTH, 4, max ops outstanding (in flight + buffered); power of two, at least 2
TAG_W, 5, destination tag width (register index or ROB/RS tag)
DATA_W, 32, result width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
issue_valid  in  1  dispatcher requests an op
issue_tag  in  TAG_W  destination tag of that op
issue_ready  out  1  credit available (count < DEPTH)
fu_en  out  1  EN to FU; equals issue_valid & issue_ready
fu_finish  in  1  FU result strobe, one cycle per op
fu_res  in  DATA_W  FU result, valid while fu_finish=1
wb_valid  out  1  head result available
wb_tag  out  TAG_W  tag of head result
wb_data  out  DATA_W  head result data
wb_ready  in  1  writeback accepts head this cycle
flush  in  1  discard all outstanding and buffered ops
proto_err  out  1  sticky: fu_finish seen with no op outstanding

Behaviour:
- Reset: issue_ready=1, fu_en=0, wb_valid=0, wb_tag=0, wb_data=0, proto_err=0, all pointers and counters 0. Reset overrides flush and all inputs.
- Issue: on accept (fu_en=1), push issue_tag into the tag FIFO (DEPTH entries) and increment count.
- Credit count tracks in-flight tags + buffered results + pending drops. issue_ready=(count<DEPTH), purely from registered count. Issue never depends on wb_ready.
- Completion on fu_finish=1:
  - drop_cnt>0: discard the result and decrement drop_cnt and count.
  - Otherwise, tag FIFO non-empty: pop head tag and push {tag, fu_res} into the result FIFO (DEPTH entries).
  - Otherwise: set proto_err; the result is ignored.
- Result FIFO cannot overflow: credit accounting guarantees a slot.
- Output: wb_valid = result FIFO non-empty. wb_tag and wb_data come from the head entry, held stable while wb_valid & ~wb_ready. A pop (wb_valid & wb_ready) decrements count.
- Latency: finish at cycle N gives wb_valid at N+1 when the result FIFO was empty.
- Simultaneous events in one cycle:
  - Issue, finish and pop all apply. Count changes by (+issue −drop −pop).
  - A buffered finish is not a count change.
- count==DEPTH-1 with issue and pop in the same cycle: count stays DEPTH-1.
- At count==DEPTH with a pop, issue_ready is still 0 that cycle; it rises the next cycle.
- Flush:
  - Same cycle: fu_en forced 0, issue_ready forced 0.
  - Next cycle: tag FIFO and result FIFO cleared, wb_valid=0, drop_cnt = in-flight count (tags still in the FU), count = drop_cnt.
  - A fu_finish in the flush cycle counts as one of the dropped results.
  - A pop in the flush cycle is ignored.
  - Issues after flush enqueue behind the pending drops. This is correct because the FU completes in order.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are tracked by occupancy counters, not pointer equality.

Optional Feature:
FU_WB_BYPASS_EN
- Defined: when the result FIFO is empty, fu_finish=1 with a matching tag, and no drop is pending, wb_valid is asserted combinationally in that same cycle with wb_tag = head tag and wb_data = fu_res.
  - If wb_ready=1, the entry is consumed without being written.
  - Otherwise it is written to the FIFO as normal.
- Undefined: minimum finish-to-wb_valid latency is 1 cycle; all outputs come from registers.

Decomposition:
- Shared package: wb_entry_t {tag, data}, DEPTH/TAG_W defaults, and the clog2 pointer-width constant, shared with FU wrappers and the CDB arbiter.
- One sub-module: sync_fifo (param WIDTH, DEPTH; push/pop/full/empty/count), instantiated twice: tag FIFO and result FIFO.
- Credit, drop and error logic stays in fu_wb_collector.

Test Plan:
- Single op: issue tag 5; finish with res=0x0000_0030 at cycle +7 -> wb_valid at finish+1 with tag 5, data 0x30; wb_ready=1 pops; count returns to 0.
- Backpressure/full: wb_ready=0, issue tags 1..4 -> issue_ready=0 after 4th accept; 4 finishes buffered. Release wb_ready -> tags 1,2,3,4 drained in order; issue_ready=1 the cycle after first pop.
- Simultaneous events: at count=3, issue+finish+pop in one cycle -> count stays 3, no lost tag, ordering preserved.
- Flush: 2 in flight, 1 buffered, flush -> wb_valid=0 next cycle, drop_cnt=2. Issue tag 9, then 3 finishes (0xA, 0xB, 0xC) -> only tag 9 / 0xC emerges.
- Protocol error: fu_finish with empty tag FIFO and drop_cnt=0 -> proto_err=1 and stays 1 until rst; no wb_valid.
- Reset mid-operation: rst while 3 ops outstanding -> next cycle all outputs at reset values, issue_ready=1. Later finishes with no outstanding op set proto_err.
